// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS single-cycle core and its program loader:
// the symbolic instruction kinds accepted by the loader, the opcode and
// funct codes consumed by the main and ALU decoders, the loader FSM state
// type and small helpers that pack R-type and I-type instruction words.
package mips_pkg;

  // Symbolic instruction kinds; NOP encodes as the all-zero word.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    SLT  = 4'd4,
    LW   = 4'd5,
    SW   = 4'd6,
    BEQ  = 4'd7,
    ADDI = 4'd8,
    J    = 4'd9,
    NOP  = 4'd10
  } instr_kind_t;

  // Main-decoder opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU-decoder funct codes for R-type instructions.
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Loader session states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } loader_state_t;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_prog_loader_instr_enc.sv
// instr_enc
// Purely combinational encoder from a symbolic instruction request to the
// 32-bit machine word the core decodes. Fields a kind does not use are
// ignored. Any kind value outside the defined set reports legal_o = 0 and
// produces an all-zero word.
// Ports:
//   kind_i    instruction kind (instr_kind_t encoding, raw 4 bits)
//   rs_i/rt_i/rd_i  register fields
//   imm_i     16-bit immediate or branch offset
//   target_i  26-bit jump target
//   word_o    encoded instruction
//   legal_o   1 when kind_i is a defined kind
module instr_enc
  import mips_pkg::*;
(
  input  logic [3:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b1;
    case (kind_i)
      ADD:     word_o = rtype(rs_i, rt_i, rd_i, FUNCT_ADD);
      SUB:     word_o = rtype(rs_i, rt_i, rd_i, FUNCT_SUB);
      AND:     word_o = rtype(rs_i, rt_i, rd_i, FUNCT_AND);
      OR:      word_o = rtype(rs_i, rt_i, rd_i, FUNCT_OR);
      SLT:     word_o = rtype(rs_i, rt_i, rd_i, FUNCT_SLT);
      LW:      word_o = itype(OP_LW, rs_i, rt_i, imm_i);
      SW:      word_o = itype(OP_SW, rs_i, rt_i, imm_i);
      BEQ:     word_o = itype(OP_BEQ, rs_i, rt_i, imm_i);
      ADDI:    word_o = itype(OP_ADDI, rs_i, rt_i, imm_i);
      J:       word_o = {OP_J, target_i};
      NOP:     word_o = '0;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader
// Accepts symbolic instruction requests over a valid/ready handshake,
// encodes each one and writes it into instruction memory at consecutive
// word addresses starting from 0. A session opens on start (IDLE only) and
// closes after a request flagged last, or when memory fills up.
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   start                 opens a session when idle
//   req_valid/req_ready   request handshake
//   req_kind, req_rs, req_rt, req_rd, req_imm, req_target, req_last
//                         request payload
//   imem_we/imem_addr/imem_wd   instruction-memory write port
//   busy, done            session status; done pulses for one cycle
//   count                 words written this session
//   err_illegal           sticky: undefined kind received
//   err_overflow          sticky: memory filled before last
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_kind,
  input  logic [4:0]    req_rs,
  input  logic [4:0]    req_rt,
  input  logic [4:0]    req_rd,
  input  logic [15:0]   req_imm,
  input  logic [25:0]   req_target,
  input  logic          req_last,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wd,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          err_illegal,
  output logic          err_overflow
);

  loader_state_t state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          we_q, we_d;
  logic [31:0]   wd_q, wd_d;
  logic          endPend_q, endPend_d;
  logic          errIllegal_q, errIllegal_d;
  logic          errOverflow_q, errOverflow_d;

  logic [31:0]   encWord;
  logic          encLegal;
  logic          accept;
  logic [AW:0]   fillAfter;
  logic          reachFull;

  instr_enc u_enc (
    .kind_i   (req_kind),
    .rs_i     (req_rs),
    .rt_i     (req_rt),
    .rd_i     (req_rd),
    .imm_i    (req_imm),
    .target_i (req_target),
    .word_o   (encWord),
    .legal_o  (encLegal)
  );

  // Once the closing request is taken, ready drops so nothing sneaks in
  // during the final write cycle.
  assign req_ready = (state_q == ST_LOAD) && !endPend_q;
  assign accept    = req_valid && req_ready;

  // Words committed once this accept lands: those already counted, the one
  // being written right now, and this one.
  assign fillAfter = count_q + {{AW{1'b0}}, we_q} + (AW+1)'(1);
  assign reachFull = (fillAfter == (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      count_q       <= '0;
      we_q          <= 1'b0;
      wd_q          <= '0;
      endPend_q     <= 1'b0;
      errIllegal_q  <= 1'b0;
      errOverflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      count_q       <= count_d;
      we_q          <= we_d;
      wd_q          <= wd_d;
      endPend_q     <= endPend_d;
      errIllegal_q  <= errIllegal_d;
      errOverflow_q <= errOverflow_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    we_d          = 1'b0;
    wd_d          = wd_q;
    endPend_d     = endPend_q;
    errIllegal_d  = errIllegal_q;
    errOverflow_d = errOverflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_LOAD;
          ptr_d         = '0;
          count_d       = '0;
          endPend_d     = 1'b0;
          errIllegal_d  = 1'b0;
          errOverflow_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // The pointer advances at the end of the cycle in which it is used.
        if (we_q) begin
          ptr_d   = ptr_q + AW'(1);
          count_d = count_q + (AW+1)'(1);
        end
        if (endPend_q) begin
          state_d = ST_FIN;
        end else if (accept) begin
          if (encLegal) begin
            we_d = 1'b1;
            wd_d = encWord;
            if (!req_last && reachFull) begin
              errOverflow_d = 1'b1;
              endPend_d     = 1'b1;
            end
          end else begin
            errIllegal_d = 1'b1;
          end
          if (req_last) begin
            endPend_d = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d   = ST_IDLE;
        endPend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_we      = we_q;
  assign imem_addr    = ptr_q;
  assign imem_wd      = wd_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FIN);
  assign count        = count_q;
  assign err_illegal  = errIllegal_q;
  assign err_overflow = errOverflow_q;

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb_mips_prog_loader
// Directed bench for the program loader. Instance A uses the default
// 64-word memory; instance B uses a 4-word memory to reach the fill limit.
// Both share clock, reset and request payload; each has its own start so
// only the addressed instance opens a session. Inputs change just after the
// falling edge and outputs are sampled at falling edges.
module tb_mips_prog_loader;
  import mips_pkg::*;

  typedef struct {
    int          addr;
    logic [31:0] wd;
    int          cyc;
  } wr_t;

  logic        clk;
  logic        resetN;
  logic        startA, startB;
  logic        reqValid;
  logic [3:0]  reqKind;
  logic [4:0]  reqRs, reqRt, reqRd;
  logic [15:0] reqImm;
  logic [25:0] reqTarget;
  logic        reqLast;

  logic        readyA, weA, busyA, doneA, errIllA, errOvfA;
  logic [5:0]  addrA;
  logic [31:0] wdA;
  logic [6:0]  countA;

  logic        readyB, weB, busyB, doneB, errIllB, errOvfB;
  logic [1:0]  addrB;
  logic [31:0] wdB;
  logic [2:0]  countB;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  wr_t logA[$];
  wr_t logB[$];

  mips_prog_loader u_dutA (
    .clk(clk), .reset_n(resetN), .start(startA),
    .req_valid(reqValid), .req_ready(readyA), .req_kind(reqKind),
    .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd), .req_imm(reqImm),
    .req_target(reqTarget), .req_last(reqLast),
    .imem_we(weA), .imem_addr(addrA), .imem_wd(wdA),
    .busy(busyA), .done(doneA), .count(countA),
    .err_illegal(errIllA), .err_overflow(errOvfA)
  );

  mips_prog_loader #(.DEPTH(4)) u_dutB (
    .clk(clk), .reset_n(resetN), .start(startB),
    .req_valid(reqValid), .req_ready(readyB), .req_kind(reqKind),
    .req_rs(reqRs), .req_rt(reqRt), .req_rd(reqRd), .req_imm(reqImm),
    .req_target(reqTarget), .req_last(reqLast),
    .imem_we(weB), .imem_addr(addrB), .imem_wd(wdB),
    .busy(busyB), .done(doneB), .count(countB),
    .err_illegal(errIllB), .err_overflow(errOvfB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Write logs, sampled mid-cycle.
  always @(negedge clk) begin
    if (weA === 1'b1) logA.push_back('{addr: int'(addrA), wd: wdA, cyc: cycle});
    if (weB === 1'b1) logB.push_back('{addr: int'(addrB), wd: wdB, cyc: cycle});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one request and holds it until accepted or the bound expires.
  // Called just after a falling edge; returns just after the falling edge
  // that follows the handshake edge (the write cycle of that request).
  task automatic applyStimulus(input bit useB, input logic [3:0] kind,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [15:0] imm,
                               input logic [25:0] tgt, input logic last,
                               output bit accepted);
    int guard;
    reqKind = kind; reqRs = rs; reqRt = rt; reqRd = rd;
    reqImm = imm; reqTarget = tgt; reqLast = last; reqValid = 1'b1;
    guard = 0;
    while (((useB ? readyB : readyA) !== 1'b1) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard < 20) begin
      @(negedge clk);
      accepted = 1'b1;
    end else begin
      accepted = 1'b0;
    end
    reqValid = 1'b0;
    reqLast  = 1'b0;
  endtask

  task automatic pulseStart(input bit useB);
    if (useB) startB = 1'b1; else startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic test_reset;
    resetN = 1'b0;
    #1;
    compared++; if (weA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_we: got %b want 0", weA); end
    compared++; if (readyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready: got %b want 0", readyA); end
    compared++; if ({busyA, doneA, errIllA, errOvfA} !== 4'b0000) begin mismatched++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {busyA, doneA, errIllA, errOvfA}); end
    compared++; if ({countA, addrA, wdA} !== '0) begin mismatched++;
      $display("[TB] FAIL reset_regs: got count=%0d addr=%0d wd=%h want 0", countA, addrA, wdA); end
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b want 0", busyA); end
  endtask

  task automatic test_single;
    bit acc;
    logA.delete();
    pulseStart(0);
    compared++; if (readyA !== 1'b1) begin mismatched++; $display("[TB] FAIL load_ready: got %b want 1", readyA); end
    applyStimulus(0, ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b1, acc);
    compared++; if (acc !== 1'b1) begin mismatched++; $display("[TB] FAIL single_accept: got %b want 1", acc); end
    compared++; if ({weA, addrA, wdA} !== {1'b1, 6'd0, 32'h00221820}) begin mismatched++;
      $display("[TB] FAIL single_write: got we=%b addr=%0d wd=%h want we=1 addr=0 wd=00221820", weA, addrA, wdA); end
    compared++; if ({readyA, doneA} !== 2'b00) begin mismatched++;
      $display("[TB] FAIL single_wcycle: got ready=%b done=%b want 0 0", readyA, doneA); end
    @(negedge clk);
    compared++; if ({doneA, busyA, weA} !== 3'b110) begin mismatched++;
      $display("[TB] FAIL single_done: got done=%b busy=%b we=%b want 1 1 0", doneA, busyA, weA); end
    compared++; if (countA !== 7'd1) begin mismatched++; $display("[TB] FAIL single_count: got %0d want 1", countA); end
    @(negedge clk);
    compared++; if ({doneA, busyA} !== 2'b00) begin mismatched++;
      $display("[TB] FAIL single_end: got done=%b busy=%b want 0 0", doneA, busyA); end
  endtask

  task automatic test_back_to_back;
    bit acc;
    int guard;
    logic [31:0] expWd [5];
    expWd = '{32'h8C020004, 32'hAC220008, 32'h1022FFFF, 32'h20010005, 32'h08000010};
    logA.delete();
    pulseStart(0);
    applyStimulus(0, LW,   5'd0, 5'd2, 5'd0, 16'h0004, 26'd0, 1'b0, acc);
    applyStimulus(0, SW,   5'd1, 5'd2, 5'd0, 16'h0008, 26'd0, 1'b0, acc);
    applyStimulus(0, BEQ,  5'd1, 5'd2, 5'd0, 16'hFFFF, 26'd0, 1'b0, acc);
    applyStimulus(0, ADDI, 5'd0, 5'd1, 5'd0, 16'h0005, 26'd0, 1'b0, acc);
    applyStimulus(0, J,    5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 1'b1, acc);
    guard = 0;
    while (busyA !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    compared++; if (guard >= 50) begin mismatched++; $display("[TB] FAIL b2b_timeout: busy=%b want 0", busyA); end
    compared++; if (logA.size() != 5) begin mismatched++; $display("[TB] FAIL b2b_nwrites: got %0d want 5", logA.size()); end
    for (int i = 0; i < 5 && i < logA.size(); i++) begin
      compared++;
      if (logA[i].addr != i || logA[i].wd !== expWd[i] || logA[i].cyc != logA[0].cyc + i) begin
        mismatched++;
        $display("[TB] FAIL b2b_word%0d: got addr=%0d wd=%h cyc=%0d want addr=%0d wd=%h cyc=%0d",
                 i, logA[i].addr, logA[i].wd, logA[i].cyc, i, expWd[i], logA[0].cyc + i);
      end
    end
    compared++; if (countA !== 7'd5) begin mismatched++; $display("[TB] FAIL b2b_count: got %0d want 5", countA); end
  endtask

  task automatic test_rtype;
    bit acc;
    int guard;
    logic [31:0] expWd [5];
    expWd = '{32'h00221822, 32'h00221824, 32'h00221825, 32'h0022182A, 32'h00000000};
    logA.delete();
    pulseStart(0);
    applyStimulus(0, SUB, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h3FFFFFF, 1'b0, acc);
    applyStimulus(0, AND, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0, acc);
    applyStimulus(0, OR,  5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0, acc);
    applyStimulus(0, SLT, 5'd1, 5'd2, 5'd3, 16'h0000, 26'd0, 1'b0, acc);
    applyStimulus(0, NOP, 5'd7, 5'd7, 5'd7, 16'hFFFF, 26'h155, 1'b1, acc);
    guard = 0;
    while (busyA !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    compared++; if (guard >= 50) begin mismatched++; $display("[TB] FAIL rtype_timeout: busy=%b want 0", busyA); end
    compared++; if (logA.size() != 5) begin mismatched++; $display("[TB] FAIL rtype_nwrites: got %0d want 5", logA.size()); end
    for (int i = 0; i < 5 && i < logA.size(); i++) begin
      compared++;
      if (logA[i].addr != i || logA[i].wd !== expWd[i]) begin
        mismatched++;
        $display("[TB] FAIL rtype_word%0d: got addr=%0d wd=%h want addr=%0d wd=%h",
                 i, logA[i].addr, logA[i].wd, i, expWd[i]);
      end
    end
  endtask

  task automatic test_illegal;
    bit acc;
    int guard;
    logA.delete();
    pulseStart(0);
    applyStimulus(0, ADD,   5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, acc);
    applyStimulus(0, 4'd15, 5'd9, 5'd9, 5'd9, 16'd0, 26'd0, 1'b0, acc);
    compared++; if (acc !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_consumed: got %b want 1", acc); end
    applyStimulus(0, ADD,   5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1, acc);
    guard = 0;
    while (busyA !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    compared++; if (guard >= 50) begin mismatched++; $display("[TB] FAIL illegal_timeout: busy=%b want 0", busyA); end
    compared++; if (logA.size() != 2) begin mismatched++; $display("[TB] FAIL illegal_nwrites: got %0d want 2", logA.size()); end
    if (logA.size() == 2) begin
      compared++;
      if (logA[0].addr != 0 || logA[0].wd !== 32'h00221820 || logA[1].addr != 1 || logA[1].wd !== 32'h00853020) begin
        mismatched++;
        $display("[TB] FAIL illegal_words: got %0d:%h %0d:%h want 0:00221820 1:00853020",
                 logA[0].addr, logA[0].wd, logA[1].addr, logA[1].wd);
      end
    end
    compared++; if ({errIllA, errOvfA} !== 2'b10) begin mismatched++;
      $display("[TB] FAIL illegal_flags: got ill=%b ovf=%b want 1 0", errIllA, errOvfA); end
    compared++; if (countA !== 7'd2) begin mismatched++; $display("[TB] FAIL illegal_count: got %0d want 2", countA); end
    repeat (3) @(negedge clk);
    compared++; if (errIllA !== 1'b1) begin mismatched++; $display("[TB] FAIL illegal_sticky: got %b want 1", errIllA); end
  endtask

  task automatic test_start_ignored;
    bit acc;
    int guard;
    logA.delete();
    pulseStart(0);
    compared++; if ({errIllA, countA} !== {1'b0, 7'd0}) begin mismatched++;
      $display("[TB] FAIL restart_clear: got ill=%b count=%0d want 0 0", errIllA, countA); end
    applyStimulus(0, ADD, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 1'b0, acc);
    startA = 1'b1;
    applyStimulus(0, ADD, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0, 1'b1, acc);
    startA = 1'b0;
    guard = 0;
    while (busyA !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    compared++; if (guard >= 50) begin mismatched++; $display("[TB] FAIL startign_timeout: busy=%b want 0", busyA); end
    compared++; if (logA.size() != 2) begin mismatched++; $display("[TB] FAIL startign_nwrites: got %0d want 2", logA.size()); end
    if (logA.size() == 2) begin
      compared++;
      if (logA[1].addr != 1 || logA[1].wd !== 32'h00853020) begin
        mismatched++;
        $display("[TB] FAIL startign_ptr: got addr=%0d wd=%h want addr=1 wd=00853020", logA[1].addr, logA[1].wd);
      end
    end
    compared++; if (countA !== 7'd2) begin mismatched++; $display("[TB] FAIL startign_count: got %0d want 2", countA); end
  endtask

  task automatic test_overflow;
    bit acc;
    logB.delete();
    pulseStart(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, ADD, 5'd1, 5'd2, 5'(i), 16'd0, 26'd0, 1'b0, acc);
    end
    compared++; if ({readyB, weB, errOvfB} !== 3'b011) begin mismatched++;
      $display("[TB] FAIL ovf_wcycle: got ready=%b we=%b ovf=%b want 0 1 1", readyB, weB, errOvfB); end
    applyStimulus(1, ADD, 5'd1, 5'd2, 5'd9, 16'd0, 26'd0, 1'b0, acc);
    compared++; if (acc !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_fifth: got accepted=%b want 0", acc); end
    compared++; if (logB.size() != 4) begin mismatched++; $display("[TB] FAIL ovf_nwrites: got %0d want 4", logB.size()); end
    for (int i = 0; i < 4 && i < logB.size(); i++) begin
      compared++;
      if (logB[i].addr != i || logB[i].wd !== (32'h00220020 | (32'(i) << 11))) begin
        mismatched++;
        $display("[TB] FAIL ovf_word%0d: got addr=%0d wd=%h want addr=%0d wd=%h",
                 i, logB[i].addr, logB[i].wd, i, 32'h00220020 | (32'(i) << 11));
      end
    end
    compared++; if ({errOvfB, errIllB, busyB, countB} !== {3'b100, 3'd4}) begin mismatched++;
      $display("[TB] FAIL ovf_final: got ovf=%b ill=%b busy=%b count=%0d want 1 0 0 4", errOvfB, errIllB, busyB, countB); end
  endtask

  task automatic test_reset_mid;
    bit acc;
    int guard;
    pulseStart(0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, ADD, 5'd1, 5'd2, 5'(i), 16'd0, 26'd0, 1'b0, acc);
    end
    compared++; if ({weA, addrA} !== {1'b1, 6'd2}) begin mismatched++;
      $display("[TB] FAIL rstmid_third: got we=%b addr=%0d want 1 2", weA, addrA); end
    #2 resetN = 1'b0;
    #1;
    compared++; if (weA !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_we: got %b want 0", weA); end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    compared++; if ({busyA, readyA, countA} !== {2'b00, 7'd0}) begin mismatched++;
      $display("[TB] FAIL rstmid_idle: got busy=%b ready=%b count=%0d want 0 0 0", busyA, readyA, countA); end
    logA.delete();
    pulseStart(0);
    applyStimulus(0, ADD, 5'd7, 5'd8, 5'd9, 16'd0, 26'd0, 1'b1, acc);
    guard = 0;
    while (busyA !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    compared++; if (guard >= 50) begin mismatched++; $display("[TB] FAIL rstmid_timeout: busy=%b want 0", busyA); end
    compared++; if (logA.size() != 1) begin mismatched++; $display("[TB] FAIL rstmid_nwrites: got %0d want 1", logA.size()); end
    if (logA.size() == 1) begin
      compared++;
      if (logA[0].addr != 0 || logA[0].wd !== 32'h00E84820) begin
        mismatched++;
        $display("[TB] FAIL rstmid_restart: got addr=%0d wd=%h want addr=0 wd=00E84820", logA[0].addr, logA[0].wd);
      end
    end
  endtask

  initial begin
    startA = 1'b0; startB = 1'b0; reqValid = 1'b0; reqKind = '0;
    reqRs = '0; reqRt = '0; reqRd = '0; reqImm = '0; reqTarget = '0; reqLast = 1'b0;
    resetN = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_rtype();
    test_illegal();
    test_start_ignored();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
